riscv_aes_ctx_regfile: RTL and testbench

RISCV_AES_CTX_REGFILE -- requirements
Module: riscv_aes_ctx_regfile

---
 rtl/riscv_aes_ctx_regfile.sv | 148 ++++++++++++++
 tb/tb_riscv_aes_ctx_regfile.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_aes_ctx_regfile.sv
// Multi-context AES operand register file: per-context data/key/writeback storage with a
// start/ready issue port. Optional AES_KEY_WIPE_EN zeroes a context's key once it has been issued.
module riscv_aes_ctx_regfile #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int NUM_CTX    = 4,
    localparam int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            test_en_i,
    input  logic [1:0]                      instruction_sel_i,
    input  logic [CTX_W-1:0]                ctx_sel_i,
    input  logic [ADDR_WIDTH-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic                            wen_i,
    input  logic                            aes_start_i,
    input  logic                            aes_ready_i,
    input  logic                            aes_done_i,
    input  logic [CTX_W-1:0]                aes_done_ctx_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rkey_o,
    output logic [DATA_WIDTH-1:0]           wb_addr_o,
    output logic [CTX_W-1:0]                ctx_id_o,
    output logic                            aes_start_o,
    output logic [NUM_CTX-1:0]              busy_o,
    output logic                            err_o
);

    // state   | meaning
    // S_IDLE  | no issue pending; start requests may be accepted
    // S_ISSUE | snapshot presented on outputs, waiting for aes_ready_i
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CTX_W:0]      L_NCTX   = NUM_CTX[CTX_W:0];
    localparam logic [ADDR_WIDTH:0] L_NWORDS = NUM_WORDS[ADDR_WIDTH:0];

    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_KEY  = 2'd1;
    localparam logic [1:0] SEL_RSVD = 2'd2;
    localparam logic [1:0] SEL_WB   = 2'd3;

    logic [0:0]                                    r_state;
    logic [NUM_CTX-1:0][NUM_WORDS-1:0][DATA_WIDTH-1:0] r_data;
    logic [NUM_CTX-1:0][NUM_WORDS-1:0][DATA_WIDTH-1:0] r_key;
    logic [NUM_CTX-1:0][DATA_WIDTH-1:0]            r_wb;
    logic [NUM_CTX-1:0]                            r_busy;
    logic                                          r_err;
    logic [NUM_WORDS*DATA_WIDTH-1:0]               r_rdata;
    logic [NUM_WORDS*DATA_WIDTH-1:0]               r_rkey;
    logic [DATA_WIDTH-1:0]                         r_wb_addr;
    logic [CTX_W-1:0]                              r_ctx_id;

    logic              w_ctx_ok;
    logic              w_addr_ok;
    logic              w_done_ok;
    logic              w_ctx_busy;
    logic              w_wr_ok;
    logic              w_st_ok;
    logic              w_err_evt;
    logic [WIDX_W-1:0] w_widx;
    logic              w_unused;

    assign w_ctx_ok   = {1'b0, ctx_sel_i} < L_NCTX;
    assign w_done_ok  = {1'b0, aes_done_ctx_i} < L_NCTX;
    assign w_addr_ok  = {1'b0, waddr_i} < L_NWORDS;
    assign w_ctx_busy = w_ctx_ok && r_busy[ctx_sel_i];
    assign w_widx     = waddr_i[WIDX_W-1:0];
    assign w_unused   = test_en_i ^ (^waddr_i);

    // Writeback-address writes carry no word index, so waddr_i range is irrelevant for them.
    assign w_wr_ok = wen_i && (instruction_sel_i != SEL_RSVD) && w_ctx_ok && !w_ctx_busy
                     && ((instruction_sel_i == SEL_WB) || w_addr_ok);

    // Writes and starts share ctx_sel_i, so any concurrent write collides with the start.
    assign w_st_ok = aes_start_i && (r_state == S_IDLE) && w_ctx_ok && !w_ctx_busy && !wen_i;

    assign w_err_evt = (wen_i && !w_wr_ok) || (aes_start_i && !w_st_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_key     <= '0;
            r_wb      <= '0;
            r_busy    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_rkey    <= '0;
            r_wb_addr <= '0;
            r_ctx_id  <= '0;
        end else begin
            if (w_err_evt) begin
                r_err <= 1'b1;
            end

            if (w_wr_ok) begin
                case (instruction_sel_i)
                    SEL_DATA: r_data[ctx_sel_i][w_widx] <= wdata_i;
                    SEL_KEY:  r_key[ctx_sel_i][w_widx]  <= wdata_i;
                    default:  r_wb[ctx_sel_i]           <= wdata_i;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_st_ok) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            r_rdata[(NUM_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH] <= r_data[ctx_sel_i][i];
                            r_rkey[(NUM_WORDS-1-i)*DATA_WIDTH +: DATA_WIDTH]  <= r_key[ctx_sel_i][i];
                        end
                        r_wb_addr <= r_wb[ctx_sel_i];
                        r_ctx_id  <= ctx_sel_i;
                        r_state   <= S_ISSUE;
                    end
                end
                default: begin
                    if (aes_ready_i) begin
                        r_state <= S_IDLE;
`ifdef AES_KEY_WIPE_EN
                        r_key[r_ctx_id] <= '0;
`endif
                    end
                end
            endcase

            // Clear before set: a done for an idle context must not cancel a fresh accept.
            if (aes_done_i && w_done_ok) begin
                r_busy[aes_done_ctx_i] <= 1'b0;
            end
            if (w_st_ok) begin
                r_busy[ctx_sel_i] <= 1'b1;
            end
        end
    end

    assign rdata_o     = r_rdata;
    assign rkey_o      = r_rkey;
    assign wb_addr_o   = r_wb_addr;
    assign ctx_id_o    = r_ctx_id;
    assign aes_start_o = (r_state == S_ISSUE);
    assign busy_o      = r_busy;
    assign err_o       = r_err;

endmodule

// File: tb/tb_riscv_aes_ctx_regfile.sv
// Randomized self-checking bench for riscv_aes_ctx_regfile against a behavioural model;
// a second 2-word instance covers the out-of-range word index case.
module tb_riscv_aes_ctx_regfile;

    localparam int NW = 4;
    localparam int NC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         test_en;
    logic [1:0]   sel;
    logic [1:0]   ctx;
    logic [1:0]   waddr;
    logic [31:0]  wdata;
    logic         wen;
    logic         start;
    logic         ready;
    logic         done;
    logic [1:0]   dctx;

    logic [127:0] rdata, rkey;
    logic [31:0]  wb_addr;
    logic [1:0]   ctx_id;
    logic         start_o;
    logic [3:0]   busy;
    logic         err;

    logic [1:0]   sel2, waddr2;
    logic [31:0]  wdata2;
    logic         wen2, start2, ready2;
    logic [63:0]  rdata2, rkey2;
    logic [31:0]  wb2;
    logic [1:0]   ctx_id2;
    logic         start_o2, err2;
    logic [3:0]   busy2;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0]  m_data[NC][NW];
    logic [31:0]  m_key[NC][NW];
    logic [31:0]  m_wb[NC];
    logic [3:0]   m_busy;
    logic         m_err;
    logic         m_issue;
    logic [127:0] m_rdata, m_rkey;
    logic [31:0]  m_wbo;
    logic [1:0]   m_ctx;

    always #5 clk = ~clk;

    riscv_aes_ctx_regfile u_dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .instruction_sel_i(sel),
        .ctx_sel_i(ctx), .waddr_i(waddr), .wdata_i(wdata), .wen_i(wen),
        .aes_start_i(start), .aes_ready_i(ready), .aes_done_i(done), .aes_done_ctx_i(dctx),
        .rdata_o(rdata), .rkey_o(rkey), .wb_addr_o(wb_addr), .ctx_id_o(ctx_id),
        .aes_start_o(start_o), .busy_o(busy), .err_o(err)
    );

    riscv_aes_ctx_regfile #(.ADDR_WIDTH(2), .NUM_WORDS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .test_en_i(1'b0), .instruction_sel_i(sel2),
        .ctx_sel_i(2'd0), .waddr_i(waddr2), .wdata_i(wdata2), .wen_i(wen2),
        .aes_start_i(start2), .aes_ready_i(ready2), .aes_done_i(1'b0), .aes_done_ctx_i(2'd0),
        .rdata_o(rdata2), .rkey_o(rkey2), .wb_addr_o(wb2), .ctx_id_o(ctx_id2),
        .aes_start_o(start_o2), .busy_o(busy2), .err_o(err2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_wb[c] = '0;
            for (int w = 0; w < NW; w++) begin
                m_data[c][w] = '0;
                m_key[c][w]  = '0;
            end
        end
        m_busy = '0; m_err = 0; m_issue = 0;
        m_rdata = '0; m_rkey = '0; m_wbo = '0; m_ctx = '0;
    endtask

    task automatic idle_inputs();
        rst_n = 1; test_en = 0; sel = 0; ctx = 0; waddr = 0; wdata = 0;
        wen = 0; start = 0; ready = 0; done = 0; dctx = 0;
    endtask

    // Advance one clock: model applies the rules to the current inputs, then DUT outputs are compared.
    task automatic step();
        bit cb, wr_ok, st_ok;
        if (!rst_n) begin
            model_reset();
        end else begin
            cb    = m_busy[ctx];
            wr_ok = wen && sel != 2 && !cb && (sel == 3 || waddr < NW);
            st_ok = start && !m_issue && !cb && !wen;
            if ((wen && !wr_ok) || (start && !st_ok)) m_err = 1;
            if (m_issue && ready) begin
                m_issue = 0;
`ifdef AES_KEY_WIPE_EN
                for (int w = 0; w < NW; w++) m_key[m_ctx][w] = '0;
`endif
            end
            if (st_ok) begin
                m_rdata = '0; m_rkey = '0;
                for (int w = 0; w < NW; w++) begin
                    m_rdata = (m_rdata << 32) | 128'(m_data[ctx][w]);
                    m_rkey  = (m_rkey << 32)  | 128'(m_key[ctx][w]);
                end
                m_wbo = m_wb[ctx]; m_ctx = ctx;
            end
            if (wr_ok) begin
                if (sel == 0)      m_data[ctx][waddr] = wdata;
                else if (sel == 1) m_key[ctx][waddr]  = wdata;
                else               m_wb[ctx]          = wdata;
            end
            if (done) m_busy[dctx] = 0;
            if (st_ok) begin m_busy[ctx] = 1; m_issue = 1; end
        end
        @(posedge clk);
        #1;
        chk("aes_start_o", 128'(start_o), 128'(m_issue));
        chk("busy_o",      128'(busy),    128'(m_busy));
        chk("err_o",       128'(err),     128'(m_err));
        chk("rdata_o",     rdata,         m_rdata);
        chk("rkey_o",      rkey,          m_rkey);
        chk("wb_addr_o",   128'(wb_addr), 128'(m_wbo));
        chk("ctx_id_o",    128'(ctx_id),  128'(m_ctx));
    endtask

    task automatic wr(input logic [1:0] s, input logic [1:0] c, input logic [1:0] a, input logic [31:0] d);
        sel = s; ctx = c; waddr = a; wdata = d; wen = 1;
        step();
        wen = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; step(); step(); rst_n = 1;
    endtask

    int hi;

    initial begin
        idle_inputs();
        sel2 = 0; waddr2 = 0; wdata2 = 0; wen2 = 0; start2 = 0; ready2 = 0;
        model_reset();
        do_reset();
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_err",  128'(err),  128'(0));

        // basic issue with ready already high
        wr(0, 0, 0, 32'hdeadbeef); wr(0, 0, 1, 32'hdeafbabe);
        wr(0, 0, 2, 32'h00000000); wr(0, 0, 3, 32'h11111111);
        wr(1, 0, 2, 32'hcafeface); wr(3, 0, 2, 32'h01234567);
        ctx = 0; start = 1; ready = 1; step(); start = 0;
        chk("r20_start", 128'(start_o), 128'(1));
        chk("r20_rdata", rdata, 128'hdeadbeef_deafbabe_00000000_11111111);
        chk("r20_wb",    128'(wb_addr), 128'(32'h01234567));
        chk("r20_busy",  128'(busy), 128'(4'b0001));
        step();
        chk("r20_one_cycle", 128'(start_o), 128'(0));

        // ready held low for three cycles
        wr(0, 1, 0, 32'h0badf00d);
        ready = 0; ctx = 1; start = 1; step(); start = 0;
        hi = int'(start_o);
        for (int i = 0; i < 3; i++) begin ready = 0; step(); hi += int'(start_o); end
        ready = 1; step(); hi += int'(start_o);
        chk("r21_high_cycles", 128'(hi), 128'(4));
        chk("r21_busy", 128'(busy), 128'(4'b0011));
        chk("r21_err_clean", 128'(err), 128'(0));
        ready = 0;

        // write to busy context is dropped, then succeeds after done
        wr(0, 0, 0, 32'h55555555);
        chk("r22_err", 128'(err), 128'(1));
        done = 1; dctx = 0; step(); done = 0;
        chk("r22_busy_clr", 128'(busy[0]), 128'(0));
        wr(0, 0, 0, 32'h77777777);
        ctx = 0; start = 1; ready = 1; step(); start = 0;
        chk("r22_rdata", rdata, 128'h77777777_deafbabe_00000000_11111111);
        step(); ready = 0;

        // done and start to the same context in the same cycle
        wr(0, 2, 1, 32'h22222222);
        ctx = 2; start = 1; ready = 1; step(); start = 0; step();
        done = 1; dctx = 2; ctx = 2; start = 1; step(); done = 0; start = 0;
        chk("r23_busy2", 128'(busy[2]), 128'(0));
        chk("r23_no_issue", 128'(start_o), 128'(0));
        ready = 0;

        // reset during ISSUE abandons the issue
        do_reset();
        ctx = 3; start = 1; step(); start = 0;
        chk("r24_issuing", 128'(start_o), 128'(1));
        rst_n = 0; step(); rst_n = 1;
        chk("r24_rst_start", 128'(start_o), 128'(0));
        chk("r24_rst_busy",  128'(busy), 128'(0));

        // 2-word instance: index 3 out of range
        sel2 = 0; waddr2 = 1; wdata2 = 32'ha5a5a5a5; wen2 = 1; step(); wen2 = 0;
        chk("r24_w2_ok", 128'(err2), 128'(0));
        waddr2 = 3; wdata2 = 32'hffffffff; wen2 = 1; step(); wen2 = 0;
        chk("r24_w2_err", 128'(err2), 128'(1));
        start2 = 1; ready2 = 1; step(); start2 = 0;
        chk("r24_w2_start", 128'(start_o2), 128'(1));
        chk("r24_w2_rdata", 128'(rdata2), 128'(64'h00000000_a5a5a5a5));
        step(); ready2 = 0;

        // key persistence / wipe across two issues of ctx3
        do_reset();
        for (int w = 0; w < NW; w++) wr(1, 3, 2'(w), 32'hcafeface);
        ctx = 3; start = 1; ready = 1; step(); start = 0;
        chk("r25_key1", rkey, {4{32'hcafeface}});
        step();
        done = 1; dctx = 3; step(); done = 0;
        ctx = 3; start = 1; step(); start = 0;
`ifdef AES_KEY_WIPE_EN
        chk("r25_key2", rkey, 128'(0));
`else
        chk("r25_key2", rkey, {4{32'hcafeface}});
`endif
        step(); ready = 0;

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            test_en = 1'($urandom);
            wen     = ($urandom_range(0, 2) == 0);
            sel     = 2'($urandom);
            ctx     = 2'($urandom);
            waddr   = 2'($urandom);
            wdata   = $urandom;
            start   = ($urandom_range(0, 2) == 0);
            ready   = 1'($urandom);
            done    = ($urandom_range(0, 2) == 0);
            dctx    = 2'($urandom);
            step();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
